pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a single-issue pipeline.
// Chooses the next fetch address from the sequential, branch/JAL and JALR
// paths. Also handles fetch stalls, halts, misaligned redirect traps and a
// saturating count of accepted redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       pc_selection,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      alu_result,
  input  logic             stall_req,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic             fetch_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        redirect;
  logic [31:0] target;
  logic        active;
  logic        take_halt;
  logic        take_misalign;
  logic        take_redirect;

  // Decode the branch-unit request and rank the events that can be accepted
  // this cycle. In HALT, every input is ignored.
  always_comb begin
    redirect      = ex_valid & ((pc_selection == 2'b01) | (pc_selection == 2'b10));
    target        = (pc_selection == 2'b10) ? branch_target : {alu_result[31:1], 1'b0};
    active        = (state_q != HALT);
    take_halt     = active & halt_req;
    take_misalign = active & ~halt_req & redirect & (target[1:0] != 2'b00);
    take_redirect = active & ~halt_req & redirect & (target[1:0] == 2'b00);
  end

  // State register plus PC, sticky error and redirect counter. All of them
  // return to their reset values asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic. An accepted redirect always resumes RUN, even when a
  // stall is requested in the same cycle. Leaving STALL costs one re-fetch
  // cycle in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (take_halt || take_misalign) state_d = HALT;
        else if (take_redirect)         state_d = RUN;
        else if (stall_req)             state_d = STALL;
        else                            state_d = RUN;
      end
      STALL: begin
        if (take_halt || take_misalign) state_d = HALT;
        else if (take_redirect)         state_d = RUN;
        else if (stall_req)             state_d = STALL;
        else                            state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // PC, error and counter updates. The PC advances only in RUN when no event
  // is pending. It holds on halt, misalignment, stall and stall exit.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (take_misalign) begin
      misalign_d = 1'b1;
    end else if (take_redirect) begin
      pc_d = target;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (active && !halt_req && !stall_req && state_q == RUN) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Output logic. Reset masks the fetch and flush strobes. Flushes fire only
  // for a redirect accepted this cycle, including a misaligned one.
  always_comb begin
    fetch_en     = ~rst & (state_q == RUN) & ~stall_req & ~halt_req;
    if_id_flush  = ~rst & (take_redirect | take_misalign);
    id_ex_flush  = ~rst & (take_redirect | take_misalign);
    halted       = (state_q == HALT);
    pc           = pc_q;
    misalign_err = misalign_q;
    redirect_cnt = cnt_q;
  end

endmodule
